inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 139 +++++++++++++
 tb/tb_inst_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding memory request, 2-entry {pc, inst}
// buffer toward decode, redirect handling with an abandon (DROP) state.
//
//   state | meaning
//   IDLE  | no request; buffer full or waiting for decode to drain
//   REQ   | request at fetch_pc outstanding on imem
//   DROP  | abandoned request still outstanding; its data is discarded on ack
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] drop_pc, drop_pc_nxt;
    logic [31:0] pc0, pc1, word0, word1;
    logic [1:0]  count, count_nxt, count_pop;
    logic        pop, push, flush;
    logic [31:0] target;
    logic        unused_redir_lsbs;

    assign target            = {redir_pc[31:2], 2'b00};
    assign unused_redir_lsbs = ^redir_pc[1:0];

    assign inst_valid = (count != 2'd0);
    assign inst       = word0;
    assign inst_pc    = pc0;
    assign imem_req   = (state == REQ) || (state == DROP);

    always_comb begin
        imem_addr = 32'h0;
        if (state == REQ)
            imem_addr = fetch_pc;
        else if (state == DROP)
            imem_addr = drop_pc;
    end

    // Redirect wins over pop: a stale head must not be consumed on the redirect edge.
    assign pop       = inst_valid && id_ready && !redir;
    assign count_pop = count - 2'(pop);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        drop_pc_nxt  = drop_pc;
        push         = 1'b0;
        flush        = 1'b0;
        case (state)
            IDLE: begin
                if (redir) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = target;
                    state_nxt    = REQ;
                end else if (count_pop < 2'd2) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redir) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = target;
                    if (!imem_ack) begin
                        drop_pc_nxt = fetch_pc;
                        state_nxt   = DROP;
                    end
                end else if (imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    if (count_pop + 2'd1 >= 2'd2)
                        state_nxt = IDLE;
                end
            end
            DROP: begin
                if (redir) begin
                    flush        = 1'b1;
                    fetch_pc_nxt = target;
                end
                if (imem_ack)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign count_nxt = flush ? 2'd0 : count_pop + 2'(push);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop_pc  <= 32'h0;
            count    <= 2'd0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            drop_pc  <= drop_pc_nxt;
            count    <= count_nxt;
        end
    end

    // Shift buffer: entry 0 is always the head; push lands after the pop shift.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc0   <= 32'h0;
            pc1   <= 32'h0;
            word0 <= 32'h0;
            word1 <= 32'h0;
        end else if (!flush) begin
            if (pop) begin
                pc0   <= pc1;
                word0 <= word1;
            end
            if (push) begin
                if (count_pop == 2'd0) begin
                    pc0   <= fetch_pc;
                    word0 <= imem_rdata;
                end else begin
                    pc1   <= fetch_pc;
                    word1 <= imem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: programmable-latency memory model, scoreboard of
// expected {pc, inst} deliveries, and directed scenario tasks.
module tb_inst_fetch;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        imem_req, imem_ack, redir, inst_valid, id_ready;
    logic [31:0] imem_addr, imem_rdata, redir_pc, inst, inst_pc;

    logic        imem_req2, imem_ack2, inst_valid2, id_ready2;
    logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          lat = 0;
    int          wcnt = 0;
    logic        ack_force = 1'b0;
    logic        sb_on = 1'b0;
    logic [31:0] sbq[$];
    logic [31:0] exp_pc;

    inst_fetch dut (
        .clk(clk), .clr(clr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redir(redir), .redir_pc(redir_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .id_ready(id_ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .clr(clr), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redir(1'b0), .redir_pc(32'h0),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .id_ready(id_ready2)
    );

    assign imem_ack2   = imem_req2;
    assign imem_rdata2 = imem_addr2 ^ K;

    always #5 clk = ~clk;

    // Memory model: acks after 'lat' wait cycles, data = addr ^ K.
    always @(negedge clk) begin
        if (clr) begin
            wcnt       = 0;
            imem_ack   = ack_force;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ K;
                wcnt       = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack   = ack_force;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
        end
    end

    // Scoreboard: every accepted instruction must match the next expected pc.
    always @(negedge clk) begin
        if (sb_on && inst_valid && id_ready) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_mis++;
                $display("FAIL sb_unexpected: got pc %h, required none", inst_pc);
            end else begin
                exp_pc = sbq.pop_front();
                if (inst_pc !== exp_pc || inst !== (exp_pc ^ K)) begin
                    n_mis++;
                    $display("FAIL sb_deliver: got pc %h inst %h, required pc %h inst %h",
                             inst_pc, inst, exp_pc, exp_pc ^ K);
                end
            end
        end
    end

    task automatic do_reset();
        clr       = 1'b1;
        redir     = 1'b0;
        redir_pc  = 32'h0;
        ack_force = 1'b0;
        sbq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        ack_force = 1'b1;
        id_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b required 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_mis++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid: got %b required 0", inst_valid); end
        n_cmp++; if (inst !== 32'h0) begin n_mis++; $display("FAIL rst_inst: got %h required 0", inst); end
        n_cmp++; if (inst_pc !== 32'h0) begin n_mis++; $display("FAIL rst_pc: got %h required 0", inst_pc); end
        ack_force = 1'b0;
    endtask

    task automatic test_stream();
        lat = 0; id_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) sbq.push_back(32'(4 * k));
        sb_on = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_mis++; $display("FAIL stream_c1: got valid %b req %b addr %h, required 0 1 0", inst_valid, imem_req, imem_addr); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k)) begin
                n_mis++; $display("FAIL stream_pc: got valid %b pc %h, required 1 %h", inst_valid, inst_pc, 32'(4 * k)); end
        end
        @(negedge clk); #1 id_ready = 1'b0;
        n_cmp++; if (sbq.size() != 0) begin n_mis++; $display("FAIL stream_left: got %0d pending, required 0", sbq.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_stall();
        lat = 0; id_ready = 1'b0;
        do_reset();
        sbq.push_back(32'h0); sbq.push_back(32'h4); sbq.push_back(32'h8);
        sb_on = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_mis++; $display("FAIL stall_req: got %b required 0", imem_req); end
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_mis++; $display("FAIL stall_head: got valid %b pc %h, required 1 0", inst_valid, inst_pc); end
        id_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (inst_pc !== 32'h4) begin n_mis++; $display("FAIL stall_rel1: got %h required 4", inst_pc); end
        @(posedge clk); #1;
        n_cmp++; if (inst_pc !== 32'h8) begin n_mis++; $display("FAIL stall_rel2: got %h required 8", inst_pc); end
        @(negedge clk); #1 id_ready = 1'b0;
        n_cmp++; if (sbq.size() != 0) begin n_mis++; $display("FAIL stall_left: got %0d pending, required 0", sbq.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_redir_wait();
        int waited;
        lat = 3; id_ready = 1'b1;
        do_reset();
        sbq.push_back(32'h100);
        sb_on = 1'b1;
        @(posedge clk); #1;
        redir = 1'b1; redir_pc = 32'h0000_0103;
        @(posedge clk); #1;
        redir = 1'b0;
        for (int e = 0; e < 3; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
                n_mis++; $display("FAIL drop_hold: got req %b addr %h valid %b, required 1 0 0", imem_req, imem_addr, inst_valid); end
        end
        @(posedge clk); #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_mis++; $display("FAIL drop_next: got req %b addr %h, required 1 100", imem_req, imem_addr); end
        waited = 0;
        while (!inst_valid && waited < 12) begin @(posedge clk); #1; waited++; end
        n_cmp++; if (waited != 4) begin n_mis++; $display("FAIL drop_latency: got %0d cycles, required 4", waited); end
        n_cmp++; if (inst_pc !== 32'h100) begin n_mis++; $display("FAIL drop_first: got %h required 100", inst_pc); end
        @(negedge clk); #1 id_ready = 1'b0;
        n_cmp++; if (sbq.size() != 0) begin n_mis++; $display("FAIL drop_left: got %0d pending, required 0", sbq.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_redir_ack();
        lat = 0; id_ready = 1'b0;
        do_reset();
        sbq.push_back(32'h300);
        sb_on = 1'b1;
        @(posedge clk); #1;
        redir = 1'b1; redir_pc = 32'h300;
        @(posedge clk); #1;
        redir = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 32'h300 || imem_req !== 1'b1) begin
            n_mis++; $display("FAIL rack_flush: got valid %b req %b addr %h, required 0 1 300", inst_valid, imem_req, imem_addr); end
        id_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h300) begin
            n_mis++; $display("FAIL rack_first: got valid %b pc %h, required 1 300", inst_valid, inst_pc); end
        @(negedge clk); #1 id_ready = 1'b0;
        n_cmp++; if (sbq.size() != 0) begin n_mis++; $display("FAIL rack_left: got %0d pending, required 0", sbq.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_redir_full();
        lat = 0; id_ready = 1'b0;
        do_reset();
        sbq.push_back(32'h200); sbq.push_back(32'h204);
        sb_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_mis++; $display("FAIL full_pre: got valid %b req %b, required 1 0", inst_valid, imem_req); end
        redir = 1'b1; redir_pc = 32'h200; ack_force = 1'b1;
        @(posedge clk); #1;
        redir = 1'b0; ack_force = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_mis++; $display("FAIL full_flush: got valid %b req %b addr %h, required 0 1 200", inst_valid, imem_req, imem_addr); end
        id_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (inst_pc !== 32'h200) begin n_mis++; $display("FAIL full_t0: got %h required 200", inst_pc); end
        @(posedge clk); #1;
        n_cmp++; if (inst_pc !== 32'h204) begin n_mis++; $display("FAIL full_t1: got %h required 204", inst_pc); end
        @(negedge clk); #1 id_ready = 1'b0;
        n_cmp++; if (sbq.size() != 0) begin n_mis++; $display("FAIL full_left: got %0d pending, required 0", sbq.size()); end
        sb_on = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w;
        id_ready2 = 1'b1;
        do_reset();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            exp_w = 32'hFFFF_FFF8 + 32'(4 * k);
            n_cmp++; if (inst_valid2 !== 1'b1 || inst_pc2 !== exp_w || inst2 !== (exp_w ^ K)) begin
                n_mis++; $display("FAIL wrap_pc: got valid %b pc %h inst %h, required 1 %h %h",
                                  inst_valid2, inst_pc2, inst2, exp_w, exp_w ^ K); end
        end
        id_ready2 = 1'b0;
    endtask

    task automatic test_clr_mid();
        lat = 0; id_ready = 1'b0;
        do_reset();
        repeat (3) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        n_cmp++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || imem_req !== 1'b0) begin
            n_mis++; $display("FAIL clr_full: got valid %b inst %h pc %h req %b, required all 0", inst_valid, inst, inst_pc, imem_req); end
        lat = 3; id_ready = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(posedge clk); #1;
        redir = 1'b1; redir_pc = 32'h400;
        @(posedge clk); #1;
        redir = 1'b0;
        #2 clr = 1'b1; ack_force = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_mis++; $display("FAIL clr_drop: got req %b addr %h valid %b, required all 0", imem_req, imem_addr, inst_valid); end
        @(posedge clk);
        @(negedge clk);
        ack_force = 1'b0; lat = 0;
        sbq.delete();
        sbq.push_back(32'h0); sbq.push_back(32'h4);
        sb_on = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_mis++; $display("FAIL clr_restart: got req %b addr %h, required 1 0", imem_req, imem_addr); end
        @(posedge clk); #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            n_mis++; $display("FAIL clr_first: got valid %b pc %h, required 1 0", inst_valid, inst_pc); end
        @(posedge clk);
        @(negedge clk); #1 id_ready = 1'b0;
        n_cmp++; if (sbq.size() != 0) begin n_mis++; $display("FAIL clr_left: got %0d pending, required 0", sbq.size()); end
        sb_on = 1'b0;
    endtask

    initial begin
        redir      = 1'b0;
        redir_pc   = 32'h0;
        id_ready   = 1'b0;
        id_ready2  = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redir_wait();
        test_redir_ack();
        test_redir_full();
        test_wrap();
        test_clr_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
